// File: rtl/accum_warp_looper_sequencer_pkg.sv
// Shared sizing, types and helpers for the accumulate-warp loop sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package accum_warp_looper_sequencer_pkg;

    localparam int WORK_BW = 4;                    // loop counter / boundary width
    localparam int VDIM    = 2;                    // dims per loop level, VDIM-1 innermost
    localparam int N_ICFG  = 7;                    // number of config slots
    localparam int NCFG_BW = $clog2(N_ICFG + 1);   // config id width

    typedef logic [WORK_BW-1:0] work_t;
    typedef work_t [VDIM-1:0]   vec_t;
    typedef logic [NCFG_BW-1:0] id_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A job with any zero-length dimension has an empty iteration space.
    function automatic logic any_zero(input vec_t v);
        logic z;
        z = 1'b0;
        for (int d = 0; d < VDIM; d++) begin
            if (v[d] == '0) begin
                z = 1'b1;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/accum_warp_looper_sequencer_if.sv
// Job (src) and tuple (dst) buses of the loop sequencer.
// Latency: n/a (wiring only).
// Backpressure: src_rdy/src_ack and dst_rdy/dst_ack; transfer when both high.
// Ports: master = job producer / tuple consumer, slave = sequencer.
interface accum_warp_looper_sequencer_if;
    import accum_warp_looper_sequencer_pkg::*;

    // job side
    logic  src_rdy;
    logic  src_ack;
    id_t   i_id;
    vec_t  i_bend;
    vec_t  i_aend;

    // tuple side
    logic  dst_rdy;
    logic  dst_ack;
    id_t   o_id;
    vec_t  o_bofs;
    vec_t  o_aofs;
    logic  o_retire;
    logic  o_islast;

    modport master (
        output src_rdy, i_id, i_bend, i_aend, dst_ack,
        input  src_ack, dst_rdy, o_id, o_bofs, o_aofs, o_retire, o_islast
    );

    modport slave (
        input  src_rdy, i_id, i_bend, i_aend, dst_ack,
        output src_ack, dst_rdy, o_id, o_bofs, o_aofs, o_retire, o_islast
    );

endinterface

// File: rtl/accum_warp_looper_sequencer_nd_loop_counter.sv
// Multi-dimensional wrapping counter; innermost dim (VDIM-1) advances first.
// Latency: count updates the cycle after i_inc; o_last is combinational on the count.
// Backpressure: none; i_clear has priority over i_inc.
// Ports: i_end exclusive per-dim end, o_cnt current count, o_last = all dims at end-1.
module nd_loop_counter
    import accum_warp_looper_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  vec_t i_end,
    input  logic i_clear,
    input  logic i_inc,
    output vec_t o_cnt,
    output logic o_last
);

    localparam work_t ONE = work_t'(1);

    vec_t             cnt_q;
    vec_t             cnt_nxt;
    logic [VDIM-1:0]  at_end;
    logic             carry;

    // Ripple carry from innermost to outermost; a dim at end-1 wraps to 0
    // and passes the increment outward, otherwise it absorbs it.
    always_comb begin
        cnt_nxt = cnt_q;
        at_end  = '0;
        carry   = i_inc;
        for (int d = VDIM - 1; d >= 0; d--) begin
            at_end[d] = (cnt_q[d] == (i_end[d] - ONE));
            if (carry) begin
                if (at_end[d]) begin
                    cnt_nxt[d] = '0;
                end else begin
                    cnt_nxt[d] = cnt_q[d] + ONE;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_last = &at_end;

endmodule

// File: rtl/accum_warp_looper_sequencer.sv
// Walks the nested block x accum loop space of one job, one tuple per dst handshake.
// Latency: first tuple the cycle after job accept; next tuple the cycle after each ack.
// Backpressure: tuple held stable while dst_ack low; src_ack low while a job is running.
// Ports: i_clk, i_rst_n (async active-low); bus.slave carries the src job and dst tuple handshakes.
module accum_warp_looper_sequencer
    import accum_warp_looper_sequencer_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    accum_warp_looper_sequencer_if.slave  bus
);

    state_t state;
    logic   dst_rdy_q;
    id_t    id_q;
    vec_t   bend_q;
    vec_t   aend_q;

    logic   accept;
    logic   xfer;
    logic   a_last;
    logic   b_last;
    logic   job_done;

    // Jobs are only taken while idle; src_ack follows src_rdy there.
    assign accept   = bus.src_rdy & (state == IDLE);
    assign xfer     = bus.dst_ack & dst_rdy_q;
    assign job_done = xfer & a_last & b_last;

    nd_loop_counter u_aofs (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .i_end   (aend_q),
        .i_clear (accept),
        .i_inc   (xfer),
        .o_cnt   (bus.o_aofs),
        .o_last  (a_last)
    );

    // Block offsets step only when the accum space has been fully walked.
    nd_loop_counter u_bofs (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .i_end   (bend_q),
        .i_clear (accept),
        .i_inc   (xfer & a_last),
        .o_cnt   (bus.o_bofs),
        .o_last  (b_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            dst_rdy_q <= 1'b0;
            id_q      <= '0;
            bend_q    <= '0;
            aend_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q   <= bus.i_id;
                        bend_q <= bus.i_bend;
                        aend_q <= bus.i_aend;
                        // Empty jobs are consumed silently.
                        if (!any_zero(bus.i_bend) && !any_zero(bus.i_aend)) begin
                            state     <= RUN;
                            dst_rdy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (job_done) begin
                        state     <= IDLE;
                        dst_rdy_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    dst_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.src_ack  = accept;
    assign bus.dst_rdy  = dst_rdy_q;
    assign bus.o_id     = id_q;
    // Flags are qualified by dst_rdy so stale latched ends cannot raise them while idle.
    assign bus.o_retire = dst_rdy_q & a_last;
    assign bus.o_islast = dst_rdy_q & a_last & b_last;

endmodule
